// File: rtl/aes_pkg.sv
// Shared types for the vector AES datapath: byte/half-row/word/state widths,
// the two-beat assembly state and the 128-bit state assembly helper.
package aes_pkg;

   typedef logic [7:0]   byte_t;
   typedef logic [15:0]  halfrow_t;
   typedef logic [31:0]  word_t;
   typedef logic [127:0] state_t;

   typedef enum logic {
      FIRST  = 1'b0,
      SECOND = 1'b1
   } beat_e;

   // Builds the full state from the first-beat half-rows (p*) and the
   // second-beat half-rows (q*). In transpose mode the half-rows of the two
   // beats interleave into full rows; otherwise they are simply concatenated.
   function automatic state_t assemble_state(
      input logic     m,
      input halfrow_t p0, input halfrow_t p1, input halfrow_t p2, input halfrow_t p3,
      input halfrow_t q0, input halfrow_t q1, input halfrow_t q2, input halfrow_t q3
   );
      if (m)
         return {p0, q0, p1, q1, p2, q2, p3, q3};
      else
         return {p0, p1, p2, p3, q0, q1, q2, q3};
   endfunction

endpackage

// File: rtl/halfrow_pack.sv
// Combinational half-row packing of the two ALU lanes: byte-wise column
// transpose in MixColumns mode, straight 16-bit split otherwise.
module halfrow_pack
   import aes_pkg::*;
(
   input  logic [31:0] ALUresult0,
   input  logic [31:0] ALUresult1,
   input  logic        MCMode,
   output logic [15:0] halfRow0,
   output logic [15:0] halfRow1,
   output logic [15:0] halfRow2,
   output logic [15:0] halfRow3
);

   byte_t a3, a2, a1, a0;
   byte_t b3, b2, b1, b0;

   assign {a3, a2, a1, a0} = ALUresult0;
   assign {b3, b2, b1, b0} = ALUresult1;

   // Select transpose or straight packing for this beat
   always_comb begin
      if (MCMode) begin
         halfRow0 = {a3, b3};
         halfRow1 = {a2, b2};
         halfRow2 = {a1, b1};
         halfRow3 = {a0, b0};
      end else begin
         halfRow0 = ALUresult0[31:16];
         halfRow1 = ALUresult0[15:0];
         halfRow2 = ALUresult1[31:16];
         halfRow3 = ALUresult1[15:0];
      end
   end

endmodule

// File: rtl/packing_unit.sv
// Output-packing stage: registers the packed half-rows of every accepted beat
// and assembles consecutive beat pairs into a 128-bit state for write-back.
module packing_unit
   import aes_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic          flush,
   input  logic [31:0]   ALUresult0,
   input  logic [31:0]   ALUresult1,
   input  logic          MCMode,
   output logic [15:0]   halfRow0,
   output logic [15:0]   halfRow1,
   output logic [15:0]   halfRow2,
   output logic [15:0]   halfRow3,
   output logic          row_valid,
   output logic [127:0]  PackedResult,
   output logic          packed_valid
);

   halfrow_t hr0, hr1, hr2, hr3;
   halfrow_t p0_q, p1_q, p2_q, p3_q;
   logic     m_q;
   beat_e    state_q, state_d;
   logic     accept;
   logic     store_first;
   logic     complete;

   halfrow_pack u_pack (
      .ALUresult0 (ALUresult0),
      .ALUresult1 (ALUresult1),
      .MCMode     (MCMode),
      .halfRow0   (hr0),
      .halfRow1   (hr1),
      .halfRow2   (hr2),
      .halfRow3   (hr3)
   );

   // flush wins over a simultaneous beat, which is then dropped
   assign accept = in_valid & ~flush;

   // Beat-state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= FIRST;
      else
         state_q <= state_d;
   end

   // Beat-state transitions: flush restarts the pair, accepted beats alternate
   always_comb begin
      state_d = state_q;
      if (flush)
         state_d = FIRST;
      else if (in_valid)
         state_d = (state_q == FIRST) ? SECOND : FIRST;
   end

   // Datapath load strobes decoded from the beat state
   always_comb begin
      store_first = 1'b0;
      complete    = 1'b0;
      if (accept) begin
         if (state_q == FIRST)
            store_first = 1'b1;
         else
            complete = 1'b1;
      end
   end

   // Output half-rows and row_valid pulse for every accepted beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halfRow0  <= '0;
         halfRow1  <= '0;
         halfRow2  <= '0;
         halfRow3  <= '0;
         row_valid <= 1'b0;
      end else begin
         row_valid <= accept;
         if (accept) begin
            halfRow0 <= hr0;
            halfRow1 <= hr1;
            halfRow2 <= hr2;
            halfRow3 <= hr3;
         end
      end
   end

   // First-beat half-rows and the mode that governs the pair's assembly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p0_q <= '0;
         p1_q <= '0;
         p2_q <= '0;
         p3_q <= '0;
         m_q  <= 1'b0;
      end else if (store_first) begin
         p0_q <= hr0;
         p1_q <= hr1;
         p2_q <= hr2;
         p3_q <= hr3;
         m_q  <= MCMode;
      end
   end

   // 128-bit state assembly on the second beat of a pair
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         PackedResult <= '0;
         packed_valid <= 1'b0;
      end else begin
         packed_valid <= complete;
         if (complete)
            PackedResult <= assemble_state(m_q, p0_q, p1_q, p2_q, p3_q,
                                           hr0, hr1, hr2, hr3);
      end
   end

endmodule

// File: tb/tb_packing_unit.sv
// Self-checking bench for packing_unit: table-driven beats plus hand-written
// pair, flush, reset and back-to-back sequences, checked through a scoreboard.
module tb_packing_unit;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          flush;
   logic [31:0]   ALUresult0;
   logic [31:0]   ALUresult1;
   logic          MCMode;
   logic [15:0]   halfRow0, halfRow1, halfRow2, halfRow3;
   logic          row_valid;
   logic [127:0]  PackedResult;
   logic          packed_valid;

   int checks = 0;
   int errors = 0;

   // Expectations for the next active edge, written by the driver at negedge
   logic          exp_rv = 1'b0;
   logic          exp_pv = 1'b0;
   logic [63:0]   rowq[$];
   logic [127:0]  packq[$];
   logic [63:0]   last_rows = '0;
   logic [127:0]  last_packed = '0;

   // Bench-side pair model
   logic          m_second = 1'b0;
   logic [63:0]   m_p = '0;
   logic          m_m = 1'b0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        mc;
      logic [63:0] exp;
   } vec_t;

   packing_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .flush        (flush),
      .ALUresult0   (ALUresult0),
      .ALUresult1   (ALUresult1),
      .MCMode       (MCMode),
      .halfRow0     (halfRow0),
      .halfRow1     (halfRow1),
      .halfRow2     (halfRow2),
      .halfRow3     (halfRow3),
      .row_valid    (row_valid),
      .PackedResult (PackedResult),
      .packed_valid (packed_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] model_rows(input logic [31:0] a, input logic [31:0] b, input logic mc);
      if (mc)
         return {a[31:24], b[31:24], a[23:16], b[23:16], a[15:8], b[15:8], a[7:0], b[7:0]};
      else
         return {a, b};
   endfunction

   function automatic logic [127:0] model_pack(input logic m, input logic [63:0] p, input logic [63:0] q);
      if (m)
         return {p[63:48], q[63:48], p[47:32], q[47:32], p[31:16], q[31:16], p[15:0], q[15:0]};
      else
         return {p, q};
   endfunction

   // Drive one cycle of stimulus and record what the next edge must produce
   task automatic drive(input logic v, input logic f, input logic [31:0] a, input logic [31:0] b,
                        input logic mc, input logic [63:0] exp_rows);
      @(negedge clk);
      in_valid   = v;
      flush      = f;
      ALUresult0 = a;
      ALUresult1 = b;
      MCMode     = mc;
      exp_rv     = v && !f;
      exp_pv     = 1'b0;
      if (f) begin
         m_second = 1'b0;
      end else if (v) begin
         rowq.push_back(exp_rows);
         if (!m_second) begin
            m_p      = exp_rows;
            m_m      = mc;
            m_second = 1'b1;
         end else begin
            packq.push_back(model_pack(m_m, m_p, exp_rows));
            exp_pv   = 1'b1;
            m_second = 1'b0;
         end
      end
   endtask

   task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic mc);
      drive(1'b1, 1'b0, a, b, mc, model_rows(a, b, mc));
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
   endtask

   // Monitor: sample #2 after each rising edge and compare against scoreboard
   always @(posedge clk) begin
      #2;
      if (!rst_n) begin
         last_rows   = '0;
         last_packed = '0;
      end
      chk("row_valid", {127'd0, row_valid}, {127'd0, exp_rv});
      chk("packed_valid", {127'd0, packed_valid}, {127'd0, exp_pv});
      if (row_valid && rowq.size() > 0)
         last_rows = rowq.pop_front();
      chk("halfrows", {64'd0, halfRow0, halfRow1, halfRow2, halfRow3}, {64'd0, last_rows});
      if (packed_valid && packq.size() > 0)
         last_packed = packq.pop_front();
      chk("packed", PackedResult, last_packed);
   end

   vec_t tbl[6];

   initial begin
      tbl[0] = '{32'h01020304, 32'h05060708, 1'b1, 64'h0105_0206_0307_0408};
      tbl[1] = '{32'h01020304, 32'h05060708, 1'b0, 64'h0102_0304_0506_0708};
      tbl[2] = '{32'h0105090d, 32'h02060a0e, 1'b1, 64'h0102_0506_090a_0d0e};
      tbl[3] = '{32'hffffffff, 32'h00000000, 1'b1, 64'hff00_ff00_ff00_ff00};
      tbl[4] = '{32'hdeadbeef, 32'hcafef00d, 1'b0, 64'hdead_beef_cafe_f00d};
      tbl[5] = '{32'h80000001, 32'h7ffffffe, 1'b1, 64'h807f_00ff_00ff_01fe};

      rst_n = 1'b0;
      in_valid = 1'b0;
      flush = 1'b0;
      ALUresult0 = '0;
      ALUresult1 = '0;
      MCMode = 1'b0;
      #1;
      chk("reset_rows", {64'd0, halfRow0, halfRow1, halfRow2, halfRow3}, '0);
      chk("reset_packed", PackedResult, '0);
      chk("reset_valids", {126'd0, row_valid, packed_valid}, '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Table vectors, back-to-back; they also form three pairs
      for (int unsigned i = 0; i < 6; i++)
         drive(1'b1, 1'b0, tbl[i].a, tbl[i].b, tbl[i].mc, tbl[i].exp);
      idle();
      idle();

      // Transpose pair with literal result
      beat(32'h01020304, 32'h05060708, 1'b1);
      beat(32'h090a0b0c, 32'h0d0e0f10, 1'b1);
      idle();
      @(posedge clk); #3;
      chk("pair_mc1", PackedResult, 128'h0105090d_02060a0e_03070b0f_04080c10);

      // Straight pair with literal result
      beat(32'h01020304, 32'h05060708, 1'b0);
      beat(32'h090a0b0c, 32'h0d0e0f10, 1'b0);
      idle();
      @(posedge clk); #3;
      chk("pair_mc0", PackedResult, 128'h01020304_05060708_090a0b0c_0d0e0f10);

      // Mixed modes: the first beat's mode governs assembly
      beat(32'h11223344, 32'h55667788, 1'b0);
      beat(32'h99aabbcc, 32'hddeeff00, 1'b1);
      idle();

      // Flush after first beat, then a fresh pair
      beat(32'hffffffff, 32'heeeeeeee, 1'b1);
      drive(1'b0, 1'b1, '0, '0, 1'b0, '0);
      beat(32'h01020304, 32'h05060708, 1'b1);
      beat(32'h090a0b0c, 32'h0d0e0f10, 1'b1);
      idle();
      @(posedge clk); #3;
      chk("flush_new_pair", PackedResult, 128'h0105090d_02060a0e_03070b0f_04080c10);

      // Flush together with in_valid drops the beat and restarts the pair
      beat(32'h12345678, 32'h9abcdef0, 1'b0);
      drive(1'b1, 1'b1, 32'haaaaaaaa, 32'hbbbbbbbb, 1'b0, '0);
      beat(32'h0badf00d, 32'h600dcafe, 1'b0);
      beat(32'h13579bdf, 32'h2468ace0, 1'b1);
      idle();

      // Back-to-back four beats: packed_valid on the 2nd and 4th
      for (int unsigned i = 0; i < 4; i++)
         beat($urandom, $urandom, 1'($urandom_range(0, 1)));
      idle();
      idle();

      // Reset mid-pair clears outputs immediately and discards the first beat
      beat(32'hcafebabe, 32'h8badf00d, 1'b1);
      beat(32'h01020304, 32'h05060708, 1'b1);
      beat(32'h77777777, 32'h66666666, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      exp_rv   = 1'b0;
      exp_pv   = 1'b0;
      rst_n    = 1'b0;
      m_second = 1'b0;
      #1;
      chk("midpair_rst_rows", {64'd0, halfRow0, halfRow1, halfRow2, halfRow3}, '0);
      chk("midpair_rst_packed", PackedResult, '0);
      chk("midpair_rst_valids", {126'd0, row_valid, packed_valid}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      beat(32'h01020304, 32'h05060708, 1'b0);
      beat(32'h090a0b0c, 32'h0d0e0f10, 1'b0);
      idle();
      @(posedge clk); #3;
      chk("post_rst_pair", PackedResult, 128'h01020304_05060708_090a0b0c_0d0e0f10);
      idle();
      idle();

      chk("rowq_drained", 128'(rowq.size()), '0);
      chk("packq_drained", 128'(packq.size()), '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/packing_unit.md
# packing_unit

Output-packing stage of the vector AES datapath. Each beat takes the two 32-bit ALU lane results and rearranges them into four 16-bit half-rows. In MixColumns mode the lanes are transposed byte-wise; otherwise they are split straight into halves. Two consecutive beats are also assembled into a full 128-bit state for write-back.

## Interface
- Parameters: none. Widths are fixed by the AES state: 32-bit lanes, 16-bit half-rows, 128-bit state.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  beat valid; ALUresult0/1 and MCMode are sampled when high
- flush  in  1  abandon a partially assembled state
- ALUresult0  in  32  lane-0 result; byte3 = [31:24] … byte0 = [7:0]
- ALUresult1  in  32  lane-1 result, same byte order
- MCMode  in  1  1 = MixColumns (transpose) packing, 0 = straight packing
- halfRow0..halfRow3  out  16 each  packed half-rows of the last accepted beat
- row_valid  out  1  one-cycle pulse when halfRow0..3 update
- PackedResult  out  128  assembled state from the last two-beat pair
- packed_valid  out  1  one-cycle pulse when PackedResult updates

## Operation
- Lane bytes are named a3..a0 = ALUresult0[31:24..7:0] and b3..b0 = ALUresult1[31:24..7:0].
- MCMode=1, column transpose:
  - halfRow0 = {a3,b3}
  - halfRow1 = {a2,b2}
  - halfRow2 = {a1,b1}
  - halfRow3 = {a0,b0}
- MCMode=0, straight split:
  - halfRow0 = ALUresult0[31:16]
  - halfRow1 = ALUresult0[15:0]
  - halfRow2 = ALUresult1[31:16]
  - halfRow3 = ALUresult1[15:0]
- MCMode is applied per beat for halfRow generation.
- Beat counter, 1 bit: 0 = FIRST, 1 = SECOND.
  - An accepted beat in FIRST stores its half-rows (P0..P3) and its mode (M), then moves to SECOND.
  - An accepted beat in SECOND produces half-rows Q0..Q3, updates PackedResult, and returns to FIRST.
- PackedResult assembly uses mode M latched from the FIRST beat; the SECOND beat's MCMode affects only its own halfRows.
  - M=1: PackedResult = {P0,Q0,P1,Q1,P2,Q2,P3,Q3}, i.e. full rows 0..3, MSB first.
  - M=0: PackedResult = {P0,P1,P2,P3,Q0,Q1,Q2,Q3}.
- flush has priority: counter → FIRST; any in_valid in the same cycle is dropped (no row_valid, no counter advance).
- PackedResult and halfRows hold their values between updates.

## Timing
- All outputs are registered.
- Latency is 1 cycle: a beat accepted at edge N appears on halfRow0..3 with row_valid=1 after edge N; PackedResult/packed_valid follow after the same edge as the SECOND beat's halfRows.
- Full throughput: in_valid may be high every cycle. No backpressure; beats are always accepted.
- Reset, asynchronously on rst_n low:
  - halfRow0..3 = 0
  - PackedResult = 0
  - row_valid = 0
  - packed_valid = 0
  - counter = FIRST, M = 0
- Reset mid-pair discards the stored first beat.
- row_valid and packed_valid are 0 in any cycle following an edge with no accepted beat.

## Structure
- Shared package (aes_pkg):
  - byte/halfrow/word/state typedefs: 8/16/32/128 bits
  - beat-state enum {FIRST, SECOND}
- One natural sub-module, halfrow_pack: purely combinational, (ALUresult0, ALUresult1, MCMode) → four halfRows.
- Top level: registers, beat counter and 128-bit assembly.

## Test plan
- Transpose, MCMode=1, 01020304/05060708 → halfRow0..3 = 0105, 0206, 0307, 0408 one cycle later, row_valid=1.
- Straight, MCMode=0, same operands → 0102, 0304, 0506, 0708.
- Transpose of rows, MCMode=1, 0105090d/02060a0e → 0102, 0506, 090a, 0d0e.
- Two-beat pair:
  - Stimulus: MCMode=1, beat1 = 01020304/05060708, beat2 = 090a0b0c/0d0e0f10.
  - packed_valid pulses once; PackedResult = 0105090d_02060a0e_03070b0f_04080c10.
  - With MCMode=0 on both beats: PackedResult = 01020304_05060708_090a0b0c_0d0e0f10.
- Flush/reset:
  - flush after the first beat, then a new pair → PackedResult built from the new pair only.
  - flush together with in_valid → no row_valid.
  - rst_n low mid-pair → all outputs 0 immediately.
- Back-to-back: in_valid high for 4 cycles → row_valid high 4 cycles, packed_valid pulses on cycles 2 and 4.
